// File: rtl/pkt_switch_pkg.sv
// Shared defaults, destination-field width helper and arbiter state encoding
// for the parametrised packet switch.
package pkt_switch_pkg;

    localparam int unsigned N_DEFAULT     = 4;
    localparam int unsigned W_DEFAULT     = 10;
    localparam int unsigned DEPTH_DEFAULT = 8;
    localparam int unsigned CW_DEFAULT    = 5;

    // Width of the destination field carried in the top bits of each word.
    function automatic int unsigned dest_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef enum logic {
        ARB_IDLE  = 1'b0,
        ARB_GRANT = 1'b1
    } arb_state_e;

endpackage

// File: rtl/pkt_fifo.sv
// Show-ahead FIFO with occupancy counter; push on full is accepted only when
// a pop is accepted in the same cycle, pop on empty is ignored.
module pkt_fifo #(
    parameter int unsigned W     = 10,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [W-1:0]             din,
    output logic [W-1:0]             dout,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          wr_en, rd_en;

    always_comb begin
        empty    = (count_q == '0);
        full     = (count_q == (AW + 1)'(DEPTH));
        rd_en    = pop && !empty;
        wr_en    = push && (!full || rd_en);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) begin
            mem_d[wr_ptr_q] = din;
            wr_ptr_d        = wr_ptr_q + AW'(1);
        end
        if (rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (AW + 1)'(1);
            2'b01:   count_d = count_q - (AW + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/pkt_switch_n.sv
// N x N packet switch: input FIFOs, registered round-robin grant, transfer
// stage, output FIFOs. Define PKT_SWITCH_COUNTERS_EN to build per-output pop counters.
module pkt_switch_n
    import pkt_switch_pkg::*;
#(
    parameter int unsigned N     = N_DEFAULT,
    parameter int unsigned W     = W_DEFAULT,
    parameter int unsigned DEPTH = DEPTH_DEFAULT,
    parameter int unsigned CW    = CW_DEFAULT
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [$clog2(DEPTH):0]     alto,
    input  logic [$clog2(DEPTH):0]     bajo,
    input  logic [N-1:0]               push,
    input  logic [N*W-1:0]             data_in,
    input  logic [N-1:0]               pop,
    output logic [N*W-1:0]             data_out,
    output logic [2*N-1:0]             empty_fifos,
    output logic [N-1:0]               almost_empty,
    output logic [N-1:0]               overflow,
    input  logic                       idle,
    input  logic                       req,
    input  logic [dest_width(N)-1:0]   idx,
    output logic                       valid_contador,
    output logic [CW-1:0]              contador_out
);

    localparam int unsigned DW   = dest_width(N);
    localparam int unsigned CNTW = $clog2(DEPTH) + 1;

    logic [W-1:0]    in_head   [N];
    logic [CNTW-1:0] in_count  [N];
    logic [W-1:0]    out_head  [N];
    logic [CNTW-1:0] out_count [N];
    logic [N-1:0]    in_empty, in_full, in_pop;
    logic [N-1:0]    out_empty, out_full, out_push;
    logic [N-1:0]    unused_bits;

    arb_state_e      state_q, state_d;
    logic [DW-1:0]   grant_idx_q, grant_idx_d;
    logic [DW-1:0]   rr_ptr_q, rr_ptr_d;
    logic            xfer_valid_q, xfer_valid_d;
    logic [W-1:0]    xfer_word_q, xfer_word_d;
    logic [N-1:0]    ovf_q, ovf_d;

    logic [DW-1:0]   grant_dest, xfer_dest;
    logic [CNTW:0]   occ_proj;
    logic [N-1:0]    almost_full, eligible;
    logic            found;
    logic [DW-1:0]   pick, cand;

    for (genvar g = 0; g < N; g++) begin : g_ch
        pkt_fifo #(.W(W), .DEPTH(DEPTH)) u_in (
            .clk   (clk),
            .reset (reset),
            .push  (push[g]),
            .pop   (in_pop[g]),
            .din   (data_in[g*W +: W]),
            .dout  (in_head[g]),
            .empty (in_empty[g]),
            .full  (in_full[g]),
            .count (in_count[g])
        );

        pkt_fifo #(.W(W), .DEPTH(DEPTH)) u_out (
            .clk   (clk),
            .reset (reset),
            .push  (out_push[g]),
            .pop   (pop[g]),
            .din   (xfer_word_q),
            .dout  (out_head[g]),
            .empty (out_empty[g]),
            .full  (out_full[g]),
            .count (out_count[g])
        );

        assign data_out[g*W +: W] = out_head[g];
        assign almost_empty[g]    = (out_count[g] <= bajo);
        assign unused_bits[g]     = ^{in_count[g], out_full[g]};
    end

    assign empty_fifos = {out_empty, in_empty};
    assign overflow    = ovf_q;

    // Projected occupancy counts both pipeline stages so a stream stops exactly at alto.
    always_comb begin
        grant_dest = in_head[grant_idx_q][W-1 -: DW];
        xfer_dest  = xfer_word_q[W-1 -: DW];
        occ_proj   = '0;
        for (int unsigned j = 0; j < N; j++) begin
            occ_proj = {1'b0, out_count[j]}
                     + (CNTW + 1)'(xfer_valid_q && (xfer_dest == DW'(j)))
                     + (CNTW + 1)'((state_q == ARB_GRANT) && (grant_dest == DW'(j)));
            almost_full[j] = (occ_proj >= {1'b0, alto});
            out_push[j]    = xfer_valid_q && (xfer_dest == DW'(j));
        end
    end

    // The input being popped this cycle is excluded: its next head is not yet visible.
    always_comb begin
        for (int unsigned i = 0; i < N; i++) begin
            eligible[i] = !in_empty[i]
                       && !almost_full[in_head[i][W-1 -: DW]]
                       && !((state_q == ARB_GRANT) && (grant_idx_q == DW'(i)));
        end
        found = 1'b0;
        pick  = rr_ptr_q;
        cand  = rr_ptr_q;
        for (int unsigned k = 0; k < N; k++) begin
            cand = rr_ptr_q + DW'(k);
            if (!found && eligible[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end

        state_d     = ARB_IDLE;
        grant_idx_d = grant_idx_q;
        rr_ptr_d    = rr_ptr_q;
        if (found) begin
            state_d     = ARB_GRANT;
            grant_idx_d = pick;
            rr_ptr_d    = pick + DW'(1);
        end

        in_pop       = '0;
        xfer_valid_d = 1'b0;
        xfer_word_d  = xfer_word_q;
        if (state_q == ARB_GRANT) begin
            in_pop[grant_idx_q] = 1'b1;
            xfer_valid_d        = 1'b1;
            xfer_word_d         = in_head[grant_idx_q];
        end

        ovf_d = ovf_q | (push & in_full & ~in_pop);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ARB_IDLE;
            grant_idx_q  <= '0;
            rr_ptr_q     <= '0;
            xfer_valid_q <= 1'b0;
            xfer_word_q  <= '0;
            ovf_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_idx_q  <= grant_idx_d;
            rr_ptr_q     <= rr_ptr_d;
            xfer_valid_q <= xfer_valid_d;
            xfer_word_q  <= xfer_word_d;
            ovf_q        <= ovf_d;
        end
    end

`ifdef PKT_SWITCH_COUNTERS_EN
    logic [CW-1:0] cnt_q [N];
    logic [CW-1:0] cnt_d [N];
    logic          valid_q, valid_d;
    logic [CW-1:0] cont_q, cont_d;

    always_comb begin
        for (int unsigned j = 0; j < N; j++) begin
            cnt_d[j] = cnt_q[j];
            if (pop[j] && !out_empty[j] && (cnt_q[j] != '1)) begin
                cnt_d[j] = cnt_q[j] + CW'(1);
            end
        end
        valid_d = req && idle;
        cont_d  = cont_q;
        if (valid_d) begin
            cont_d = cnt_q[idx];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned j = 0; j < N; j++) begin
                cnt_q[j] <= '0;
            end
            valid_q <= 1'b0;
            cont_q  <= '0;
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            cont_q  <= cont_d;
        end
    end

    assign valid_contador = valid_q;
    assign contador_out   = cont_q;
`else
    logic unused_cnt_inputs;
    assign unused_cnt_inputs = ^{idle, req, idx};
    assign valid_contador    = 1'b0;
    assign contador_out      = '0;
`endif

endmodule

// File: tb/tb_pkt_switch_n.sv
// Directed bench for pkt_switch_n (4x4, W=10, DEPTH=8, CW=5): vector table for
// single-word routing plus hand-written multi-cycle sequences.
module tb_pkt_switch_n;

    localparam int unsigned N     = 4;
    localparam int unsigned W     = 10;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned CW    = 5;
`ifdef PKT_SWITCH_COUNTERS_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic [3:0]     alto, bajo;
    logic [N-1:0]   push, pop;
    logic [N*W-1:0] data_in, data_out;
    logic [2*N-1:0] empty_fifos;
    logic [N-1:0]   almost_empty, overflow;
    logic           idle, req;
    logic [1:0]     idx;
    logic           valid_contador;
    logic [CW-1:0]  contador_out;

    int n_vec  = 0;
    int n_miss = 0;

    typedef struct {
        int unsigned  in_ch;
        logic [W-1:0] word;
        int unsigned  exp_out;
    } vec_t;
    vec_t vecs [6];

    always #5 clk = ~clk;

    pkt_switch_n #(.N(N), .W(W), .DEPTH(DEPTH), .CW(CW)) dut (
        .clk            (clk),
        .reset          (reset),
        .alto           (alto),
        .bajo           (bajo),
        .push           (push),
        .data_in        (data_in),
        .pop            (pop),
        .data_out       (data_out),
        .empty_fifos    (empty_fifos),
        .almost_empty   (almost_empty),
        .overflow       (overflow),
        .idle           (idle),
        .req            (req),
        .idx            (idx),
        .valid_contador (valid_contador),
        .contador_out   (contador_out)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [W-1:0] head(input int unsigned j);
        return data_out[j*W +: W];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    task automatic set_word(input int unsigned i, input logic [W-1:0] w);
        data_in[i*W +: W] = w;
    endtask

    task automatic do_reset();
        push    = '0;
        pop     = '0;
        req     = 1'b0;
        idle    = 1'b0;
        idx     = '0;
        data_in = '0;
        reset   = 1'b0;
        ticks(2);
        reset   = 1'b1;
        tick();
    endtask

    // Occupancy is observed through almost_empty by sweeping bajo around the expected value.
    task automatic check_occ(input int unsigned j, input int unsigned e, input string name);
        if (e == 0) begin
            chk({name, " empty"}, 32'(empty_fifos[N+j]), 32'd1);
        end else begin
            bajo = 4'(e - 1);
            #1;
            chk({name, " occ>bajo-1"}, 32'(almost_empty[j]), 32'd0);
            bajo = 4'(e);
            #1;
            chk({name, " occ<=bajo"}, 32'(almost_empty[j]), 32'd1);
            bajo = '0;
            #1;
        end
    endtask

    task automatic pop_check(input int unsigned j, input logic [W-1:0] w, input string name);
        chk(name, 32'(head(j)), 32'(w));
        pop[j] = 1'b1;
        tick();
        pop[j] = 1'b0;
    endtask

    initial begin
        vecs[0] = '{in_ch: 0, word: 10'h0C5, exp_out: 0};
        vecs[1] = '{in_ch: 1, word: 10'h1AB, exp_out: 1};
        vecs[2] = '{in_ch: 2, word: 10'h3FF, exp_out: 3};
        vecs[3] = '{in_ch: 3, word: 10'h07E, exp_out: 0};
        vecs[4] = '{in_ch: 2, word: 10'h2F0, exp_out: 2};
        vecs[5] = '{in_ch: 0, word: 10'h155, exp_out: 1};

        alto = 4'd15;
        bajo = '0;
        push = '0;
        pop = '0;
        req = 1'b0;
        idle = 1'b0;
        idx = '0;
        data_in = '0;
        reset = 1'b0;
        tick();
        chk("rst data_out", data_out, 32'd0);
        chk("rst empty_fifos", 32'(empty_fifos), 32'hFF);
        chk("rst almost_empty", 32'(almost_empty), 32'hF);
        chk("rst overflow", 32'(overflow), 32'd0);
        chk("rst valid_contador", 32'(valid_contador), 32'd0);
        chk("rst contador_out", 32'(contador_out), 32'd0);
        reset = 1'b1;
        tick();

        // single-word routing and 3-cycle latency
        for (int unsigned v = 0; v < 6; v++) begin
            set_word(vecs[v].in_ch, vecs[v].word);
            push[vecs[v].in_ch] = 1'b1;
            tick();
            push = '0;
            chk($sformatf("v%0d in not empty", v), 32'(empty_fifos[vecs[v].in_ch]), 32'd0);
            ticks(2);
            chk($sformatf("v%0d out empty at t+2", v), 32'(empty_fifos[N+vecs[v].exp_out]), 32'd1);
            tick();
            chk($sformatf("v%0d out ready at t+3", v), 32'(empty_fifos[N+vecs[v].exp_out]), 32'd0);
            chk($sformatf("v%0d data_out", v), 32'(head(vecs[v].exp_out)), 32'(vecs[v].word));
            pop[vecs[v].exp_out] = 1'b1;
            tick();
            pop = '0;
            chk($sformatf("v%0d all empty after pop", v), 32'(empty_fifos), 32'hFF);
        end

        // all inputs to output 2: round-robin order, one per cycle
        do_reset();
        for (int unsigned i = 0; i < N; i++) set_word(i, 10'h200 + 10'(i));
        push = '1;
        tick();
        push = '0;
        ticks(2);
        check_occ(2, 0, "fanin t+2");
        for (int unsigned k = 1; k <= 4; k++) begin
            tick();
            check_occ(2, k, $sformatf("fanin t+%0d", k + 2));
        end
        chk("fanin rr_ptr wrap", 32'(dut.rr_ptr_q), 32'd0);
        for (int unsigned i = 0; i < N; i++) pop_check(2, 10'h200 + 10'(i), $sformatf("fanin head %0d", i));
        chk("fanin drained", 32'(empty_fifos), 32'hFF);

        // almost-full backpressure at alto=6
        do_reset();
        alto = 4'd6;
        push[3] = 1'b1;
        for (int unsigned k = 0; k < 10; k++) begin
            set_word(3, 10'h100 + 10'(k));
            tick();
        end
        push = '0;
        ticks(12);
        check_occ(1, 6, "alto stop");
        chk("alto in3 retains", 32'(empty_fifos[3]), 32'd0);
        pop_check(1, 10'h100, "alto head0");
        pop_check(1, 10'h101, "alto head1");
        ticks(12);
        check_occ(1, 6, "alto refill");
        chk("alto in3 still holds", 32'(empty_fifos[3]), 32'd0);
        alto = 4'd15;
        ticks(12);
        check_occ(1, 8, "alto released");
        chk("alto in3 drained", 32'(empty_fifos[3]), 32'd1);
        for (int unsigned k = 2; k < 10; k++) pop_check(1, 10'h100 + 10'(k), $sformatf("alto head%0d", k));
        chk("alto out1 empty", 32'(empty_fifos[N+1]), 32'd1);

        // input overflow while every output is held almost-full
        do_reset();
        alto = 4'd0;
        push[2] = 1'b1;
        for (int unsigned k = 0; k < 9; k++) begin
            set_word(2, 10'h300 + 10'(k));
            tick();
            if (k == 7) chk("ovf clear at full", 32'(overflow), 32'd0);
        end
        push = '0;
        chk("ovf set on 9th", 32'(overflow), 32'h4);
        alto = 4'd15;
        ticks(25);
        check_occ(3, 8, "ovf drained");
        chk("ovf in2 empty", 32'(empty_fifos[2]), 32'd1);
        chk("ovf sticky", 32'(overflow), 32'h4);
        for (int unsigned k = 0; k < 8; k++) pop_check(3, 10'h300 + 10'(k), $sformatf("ovf head%0d", k));
        chk("ovf 9th dropped", 32'(empty_fifos[N+3]), 32'd1);
        do_reset();
        chk("ovf cleared by reset", 32'(overflow), 32'd0);

        // counter read, idle gating, pop on empty not counted
        push[1] = 1'b1;
        for (int unsigned k = 0; k < 5; k++) begin
            set_word(1, 10'h2A0 + 10'(k));
            tick();
        end
        push = '0;
        ticks(15);
        check_occ(2, 5, "cnt fill");
        pop[2] = 1'b1;
        ticks(6);
        pop = '0;
        chk("cnt out2 empty", 32'(empty_fifos[N+2]), 32'd1);
        req = 1'b1; idx = 2'd2; idle = 1'b1;
        tick();
        chk("cnt valid idle=1", 32'(valid_contador), 32'(CNT_EN));
        chk("cnt value out2", 32'(contador_out), CNT_EN ? 32'd5 : 32'd0);
        idle = 1'b0;
        tick();
        chk("cnt valid idle=0", 32'(valid_contador), 32'd0);
        chk("cnt hold idle=0", 32'(contador_out), CNT_EN ? 32'd5 : 32'd0);
        idle = 1'b1; idx = 2'd0;
        tick();
        chk("cnt value out0", 32'(contador_out), 32'd0);
        req = 1'b0;
        tick();
        chk("cnt valid req=0", 32'(valid_contador), 32'd0);

        // counter saturation: 32 words through output 0
        do_reset();
        pop[0] = 1'b1;
        push = '1;
        for (int unsigned k = 0; k < 8; k++) begin
            for (int unsigned i = 0; i < N; i++) set_word(i, 10'(i * 8 + k));
            tick();
        end
        push = '0;
        ticks(60);
        pop = '0;
        chk("sat no overflow", 32'(overflow), 32'd0);
        chk("sat all drained", 32'(empty_fifos), 32'hFF);
        req = 1'b1; idx = 2'd0; idle = 1'b1;
        tick();
        req = 1'b0;
        chk("sat counter", 32'(contador_out), CNT_EN ? 32'd31 : 32'd0);

        // reset while a word sits in the transfer register
        do_reset();
        set_word(0, 10'h0C5);
        push[0] = 1'b1;
        tick();
        push = '0;
        ticks(2);
        chk("midrst word in flight", 32'(dut.xfer_valid_q), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("midrst empties", 32'(empty_fifos), 32'hFF);
        #1;
        reset = 1'b1;
        ticks(5);
        chk("midrst word dropped", 32'(empty_fifos), 32'hFF);
        chk("midrst data_out", data_out, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
